seq_control_unit: RTL and testbench

Multicycle, parametrised control unit for the processor datapath. It accepts one instruction at a time through a valid/ready handshake and splits it into opcode, register addresses and immediates. It then sequences decode, execute, memory and write-back over several cycles. Multi-cycle MUL/DIV use a start/done handshake with the ALU, with a timeout. LOAD/STORE wait on memory. Every field and control output is registered and held stable for the whole instruction.

---
 rtl/ctrl_pkg.sv | 61 ++++++
 rtl/instr_field_decoder.sv | 34 +++
 rtl/seq_control_unit.sv | 191 +++++++++++++++++++
 tb/tb_seq_control_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types, default widths and opcode classification for seq_control_unit.
package ctrl_pkg;

  localparam int unsigned OP_W_DEF        = 6;
  localparam int unsigned REG_AW_DEF      = 3;
  localparam int unsigned IMM_W_DEF       = 8;
  localparam int unsigned INSTR_W_DEF     = 32;
  localparam int unsigned ALU_TIMEOUT_DEF = 64;

  typedef enum logic [5:0] {
    OP_ADD   = 6'd1,
    OP_SUB   = 6'd2,
    OP_MOV   = 6'd3,
    OP_DIV   = 6'd4,
    OP_MUL   = 6'd5,
    OP_AND   = 6'd6,
    OP_OR    = 6'd7,
    OP_LOAD  = 6'd8,
    OP_STORE = 6'd9
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WAIT_ALU,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [2:0] {
    C_ILL,
    C_ALU,
    C_MULDIV,
    C_MOV,
    C_LOAD,
    C_STORE
  } cls_t;

  // Opcodes are passed zero-extended so the helpers work for any OP_W.
  function automatic cls_t op_class(input logic [31:0] op);
    cls_t c;
    c = C_ILL;
    case (op)
      32'(OP_ADD), 32'(OP_SUB), 32'(OP_AND), 32'(OP_OR): c = C_ALU;
      32'(OP_MUL), 32'(OP_DIV):                          c = C_MULDIV;
      32'(OP_MOV):                                       c = C_MOV;
      32'(OP_LOAD):                                      c = C_LOAD;
      32'(OP_STORE):                                     c = C_STORE;
      default:                                           c = C_ILL;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] alu_code(input logic [31:0] op);
    cls_t c;
    c = op_class(op);
    return (c == C_ALU || c == C_MULDIV) ? op : '0;
  endfunction

endpackage

// File: rtl/instr_field_decoder.sv
// Combinational split of an instruction word into its fields, MSB first,
// plus the undefined-opcode flag.
module instr_field_decoder
  import ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = OP_W_DEF,
  parameter int unsigned REG_AW  = REG_AW_DEF,
  parameter int unsigned IMM_W   = IMM_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
) (
  input  logic [INSTR_W-1:0] instr_i,
  output logic [OP_W-1:0]    opcode_o,
  output logic [REG_AW-1:0]  rdestino_o,
  output logic [REG_AW-1:0]  r1_o,
  output logic [REG_AW-1:0]  r2_o,
  output logic [IMM_W-1:0]   i1_o,
  output logic [IMM_W-1:0]   i2_o,
  output logic               illegal_o
);

  localparam int unsigned FIELDS_W = OP_W + 3 * REG_AW + 2 * IMM_W;
  localparam int unsigned LSB      = INSTR_W - FIELDS_W;

  assign {opcode_o, rdestino_o, r1_o, r2_o, i1_o, i2_o} = instr_i[INSTR_W-1:LSB];
  assign illegal_o = (op_class(32'(opcode_o)) == C_ILL);

  generate
    if (LSB > 0) begin : g_pad
      logic unused_lsbs;
      assign unused_lsbs = ^instr_i[LSB-1:0];
    end
  endgenerate

endmodule

// File: rtl/seq_control_unit.sv
// Multicycle control unit: accepts one instruction per handshake and sequences
// decode, execute, ALU wait, memory and write-back with registered controls.
module seq_control_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned OP_W        = OP_W_DEF,
  parameter int unsigned REG_AW      = REG_AW_DEF,
  parameter int unsigned IMM_W       = IMM_W_DEF,
  parameter int unsigned INSTR_W     = INSTR_W_DEF,
  parameter int unsigned ALU_TIMEOUT = ALU_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic [OP_W-1:0]    alu_control,
  output logic               alu_start,
  input  logic               alu_done,
  output logic [REG_AW-1:0]  r1,
  output logic [REG_AW-1:0]  r2,
  output logic [REG_AW-1:0]  rdestino,
  output logic [IMM_W-1:0]   i1,
  output logic [IMM_W-1:0]   i2,
  output logic               rwe,
  output logic               rwe2,
  output logic               mwe,
  output logic               mre,
  input  logic               mem_ready,
  output logic               busy,
  output logic               illegal,
  output logic               timeout
);

  localparam int unsigned FIELDS_W = OP_W + 3 * REG_AW + 2 * IMM_W;
  localparam int unsigned CNT_W    = $clog2(ALU_TIMEOUT) + 1;

  state_t              state_q;
  logic [FIELDS_W-1:0] ir_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [OP_W-1:0]     alu_control_q;
  logic                ready_q, busy_q, alu_start_q, illegal_q, timeout_q;
  logic                rwe_q, rwe2_q, mwe_q, mre_q;

  logic [OP_W-1:0]     dec_op;
  logic [REG_AW-1:0]   dec_rd, dec_r1, dec_r2;
  logic [IMM_W-1:0]    dec_i1, dec_i2;
  logic                dec_illegal;
  logic [OP_W-1:0]     ir_op;
  cls_t                ir_cls;

  instr_field_decoder #(
    .OP_W   (OP_W),
    .REG_AW (REG_AW),
    .IMM_W  (IMM_W),
    .INSTR_W(INSTR_W)
  ) u_dec (
    .instr_i   (instr),
    .opcode_o  (dec_op),
    .rdestino_o(dec_rd),
    .r1_o      (dec_r1),
    .r2_o      (dec_r2),
    .i1_o      (dec_i1),
    .i2_o      (dec_i2),
    .illegal_o (dec_illegal)
  );

  // Fields leave the chip straight from the instruction register, so they are
  // stable from DECODE onward and keep their value in IDLE.
  assign {ir_op, rdestino, r1, r2, i1, i2} = ir_q;
  assign ir_cls = op_class(32'(ir_op));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ir_q          <= '0;
      cnt_q         <= '0;
      alu_control_q <= '0;
      ready_q       <= 1'b0;
      busy_q        <= 1'b0;
      alu_start_q   <= 1'b0;
      illegal_q     <= 1'b0;
      timeout_q     <= 1'b0;
      rwe_q         <= 1'b0;
      rwe2_q        <= 1'b0;
      mwe_q         <= 1'b0;
      mre_q         <= 1'b0;
    end else begin
      alu_start_q <= 1'b0;
      illegal_q   <= 1'b0;
      timeout_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          // Start and illegal pulses are decided here so they land in the DECODE cycle.
          if (ready_q && instr_valid) begin
            ir_q          <= {dec_op, dec_rd, dec_r1, dec_r2, dec_i1, dec_i2};
            alu_control_q <= OP_W'(alu_code(32'(dec_op)));
            alu_start_q   <= (op_class(32'(dec_op)) == C_MULDIV);
            illegal_q     <= dec_illegal;
            ready_q       <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (ir_cls)
            C_ALU, C_MULDIV: state_q <= S_EXEC;
            C_MOV: begin
              rwe2_q  <= 1'b1;
              state_q <= S_WB;
            end
            C_LOAD: begin
              mre_q   <= 1'b1;
              state_q <= S_MEM;
            end
            C_STORE: begin
              mwe_q   <= 1'b1;
              state_q <= S_MEM;
            end
            default: begin
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          endcase
        end
        S_EXEC: begin
          if (ir_cls == C_MULDIV) begin
            cnt_q   <= '0;
            state_q <= S_WAIT_ALU;
          end else begin
            rwe_q   <= 1'b1;
            state_q <= S_WB;
          end
        end
        S_WAIT_ALU: begin
          if (alu_done) begin
            rwe_q   <= 1'b1;
            state_q <= S_WB;
          end else if (cnt_q == CNT_W'(ALU_TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            mre_q <= 1'b0;
            mwe_q <= 1'b0;
            if (ir_cls == C_LOAD) begin
              rwe_q   <= 1'b1;
              state_q <= S_WB;
            end else begin
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end
        S_WB: begin
          rwe_q   <= 1'b0;
          rwe2_q  <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign busy        = busy_q;
  assign alu_control = alu_control_q;
  assign alu_start   = alu_start_q;
  assign illegal     = illegal_q;
  assign timeout     = timeout_q;
  assign rwe         = rwe_q;
  assign rwe2        = rwe2_q;
  assign mwe         = mwe_q;
  assign mre         = mre_q;

endmodule

// File: tb/tb_seq_control_unit.sv
// Randomised scoreboard bench for seq_control_unit with a cycle-level reference model.
module tb_seq_control_unit;

  localparam int T   = 8;
  localparam int NUM = 68;
  localparam int K_RWE = 0, K_RWE2 = 1, K_ILL = 2, K_TO = 3, K_ST = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [5:0]  alu_control;
  logic        alu_start;
  logic        alu_done;
  logic [2:0]  r1, r2, rdestino;
  logic [7:0]  i1, i2;
  logic        rwe, rwe2, mwe, mre;
  logic        mem_ready;
  logic        busy, illegal, timeout;

  seq_control_unit #(
    .OP_W       (6),
    .REG_AW     (3),
    .IMM_W      (8),
    .INSTR_W    (32),
    .ALU_TIMEOUT(T)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_ready(instr_ready),
    .alu_control(alu_control),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .r1         (r1),
    .r2         (r2),
    .rdestino   (rdestino),
    .i1         (i1),
    .i2         (i2),
    .rwe        (rwe),
    .rwe2       (rwe2),
    .mwe        (mwe),
    .mre        (mre),
    .mem_ready  (mem_ready),
    .busy       (busy),
    .illegal    (illegal),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // a = accept edge index, lat = cycle of the completion event, len = first IDLE cycle
  typedef struct {
    int op, rd, r1, r2, i1, i2, lsb, d, m, a, kind, lat, len;
  } rec_t;

  int   total = 0;
  int   bad   = 0;
  int   p     = 0;
  rec_t sb[$];
  rec_t cur, pend;
  int   nxt_edge, idle_start, issued, gap;
  bit   hold, have_pend, mon_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (period %0d)", name, act, exp, p);
    end
  endtask

  function automatic int exp_alu(input int op);
    return (op == 1 || op == 2 || op == 4 || op == 5 || op == 6 || op == 7) ? op : 0;
  endfunction

  function automatic rec_t model(input rec_t r);
    rec_t o;
    o = r;
    case (r.op)
      1, 2, 6, 7: begin o.kind = K_RWE;  o.lat = 3; o.len = 4; end
      3:          begin o.kind = K_RWE2; o.lat = 2; o.len = 3; end
      4, 5: begin
        if (r.d != 0 && r.d <= T + 1) begin
          o.kind = K_RWE; o.lat = 2 + r.d; o.len = 3 + r.d;
        end else begin
          o.kind = K_TO; o.lat = 3 + T; o.len = 3 + T;
        end
      end
      8:       begin o.kind = K_RWE; o.lat = 3 + r.m; o.len = 4 + r.m; end
      9:       begin o.kind = K_ST;  o.lat = 2 + r.m; o.len = 3 + r.m; end
      default: begin o.kind = K_ILL; o.lat = 1;       o.len = 2;       end
    endcase
    return o;
  endfunction

  function automatic rec_t mk(input int op, rd, ra, rb, ia, ib, d, m);
    rec_t r;
    r.op = op; r.rd = rd; r.r1 = ra; r.r2 = rb; r.i1 = ia; r.i2 = ib;
    r.d = d; r.m = m; r.a = 0; r.lsb = int'($urandom_range(0, 1));
    return model(r);
  endfunction

  function automatic rec_t gen_rand();
    int s, op, d;
    s = int'($urandom_range(0, 19));
    if (s == 0)      op = 0;
    else if (s == 1) op = int'($urandom_range(10, 63));
    else             op = (s - 2) % 9 + 1;
    d = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(2, T + 1));
    return mk(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)), d, int'($urandom_range(0, 4)));
  endfunction

  function automatic rec_t next_rec(input int i);
    case (i)
      0:       return mk(1, 5, 1, 2, 8'h11, 8'h22, 0, 0);
      1:       return mk(3, 4, 0, 0, 8'hA5, 8'h3C, 0, 0);
      2:       return mk(5, 6, 3, 4, 8'h01, 8'h02, 9, 0);
      3:       return mk(5, 2, 1, 1, 8'h00, 8'hFF, 0, 0);
      4:       return mk(63, 7, 7, 7, 8'hFF, 8'hFF, 0, 0);
      5:       return mk(9, 1, 2, 3, 8'h40, 8'h00, 0, 3);
      6:       return mk(8, 3, 2, 0, 8'h40, 8'h00, 0, 3);
      7:       return mk(4, 0, 5, 6, 8'h7E, 8'h81, 2, 0);
      default: return gen_rand();
    endcase
  endfunction

  function automatic logic [31:0] pack(input rec_t r);
    return {6'(r.op), 3'(r.rd), 3'(r.r1), 3'(r.r2), 8'(r.i1), 8'(r.i2), 1'(r.lsb)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    p++;
  endtask

  task automatic drive();
    instr_valid = have_pend && ((p >= nxt_edge - 1) || (hold && p < idle_start));
    instr       = pack(pend);
    alu_done    = (cur.op == 4 || cur.op == 5) && cur.d != 0 && p == cur.a + cur.d;
    mem_ready   = (cur.op == 8 || cur.op == 9) && p == cur.a + 1 + cur.m;
  endtask

  // Monitor: per-cycle expectations from the model, completion events popped from the scoreboard.
  rec_t mon_e;
  int   mon_rel, mon_kind;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        mon_rel = p - cur.a + 1;
        chk("instr_ready", instr_ready, p >= idle_start);
        chk("busy", busy, p < idle_start);
        chk("fields", {alu_control, rdestino, r1, r2, i1, i2},
            {6'(exp_alu(cur.op)), 3'(cur.rd), 3'(cur.r1), 3'(cur.r2), 8'(cur.i1), 8'(cur.i2)});
        chk("alu_start", alu_start, (cur.op == 4 || cur.op == 5) && mon_rel == 1);
        chk("mre", mre, cur.op == 8 && mon_rel >= 2 && mon_rel <= 2 + cur.m);
        chk("mwe", mwe, cur.op == 9 && mon_rel >= 2 && mon_rel <= 2 + cur.m);
        if (rwe || rwe2 || illegal || timeout || (mwe && mem_ready)) begin
          chk("event_onehot", $countones({rwe, rwe2, illegal, timeout, mwe && mem_ready}), 1);
          mon_kind = rwe ? K_RWE : rwe2 ? K_RWE2 : illegal ? K_ILL : timeout ? K_TO : K_ST;
          if (sb.size() == 0) begin
            chk("unexpected_event", 32'(mon_kind), 32'hFFFF_FFFF);
          end else begin
            mon_e = sb.pop_front();
            chk("event_kind", 32'(mon_kind), 32'(mon_e.kind));
            chk("event_latency", 32'(p - mon_e.a + 1), 32'(mon_e.lat));
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0; alu_done = 1'b0; mem_ready = 1'b0;
    mon_en = 1'b0; issued = 0; hold = 1'b0; have_pend = 1'b0; gap = 0;
    cur = mk(0, 0, 0, 0, 0, 0, 0, 0);
    cur.a = -100;
    pend = cur;
    nxt_edge = 1 << 30; idle_start = 0;
    repeat (3) tick();
    chk("reset_fields", {alu_control, rdestino, r1, r2, i1, i2}, 0);
    chk("reset_flags", {instr_ready, busy, alu_start, rwe, rwe2, mwe, mre, illegal, timeout}, 0);
    rst = 1'b0;
    tick();
    chk("ready_after_reset", instr_ready, 1);

    // Abort a MUL while it waits on the ALU.
    instr_valid = 1'b1;
    instr = pack(mk(5, 6, 1, 2, 8'h33, 8'h44, 0, 0));
    tick();
    instr_valid = 1'b0;
    chk("abort_alu_start", alu_start, 1);
    repeat (3) tick();
    chk("abort_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_fields", {alu_control, rdestino, r1, r2, i1, i2}, 0);
    chk("abort_flags", {instr_ready, busy, alu_start, rwe, rwe2, mwe, mre, illegal, timeout}, 0);
    tick();
    chk("abort_flags_hold", {instr_ready, busy, alu_start, rwe, rwe2, mwe, mre, illegal, timeout}, 0);
    rst = 1'b0;
    tick();
    chk("abort_ready", instr_ready, 1);
    chk("abort_quiet", {busy, alu_start, rwe, rwe2, mwe, mre, illegal, timeout}, 0);

    pend = next_rec(0);
    have_pend = 1'b1;
    nxt_edge = p + 1;
    idle_start = p;
    drive();
    while (!(issued == NUM && p >= idle_start + 4) && p < 20000) begin
      tick();
      if (have_pend && p == nxt_edge) begin
        cur = pend;
        cur.a = p;
        sb.push_back(cur);
        issued++;
        mon_en = 1'b1;
        idle_start = p + cur.len - 1;
        if (issued < NUM) begin
          pend = next_rec(issued);
          gap = int'($urandom_range(0, 2));
          hold = 1'($urandom_range(0, 1));
          nxt_edge = p + cur.len + gap;
        end else begin
          have_pend = 1'b0;
        end
      end
      drive();
    end
    if (p >= 20000) chk("cycle_budget", 32'(p), 32'(idle_start + 4));
    chk("all_issued", 32'(issued), 32'(NUM));
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
